plic_claim_agent: RTL and testbench
===================================

// Module: plic_claim_agent
// PURPOSE
//  Hardware bus initiator for one PLIC context. Programs the context's enable register, claims
//  the pending source ID when the context IRQ line rises, and hands the ID to a local consumer
//  (DMA/coprocessor) via valid/ready. Writes complete once the consumer reports done.
//  Sits between the PLIC slave port and a non-CPU interrupt consumer.
// PARAMETERS
//  CTX          0     PLIC context: enable @ 24'h00_2000+CTX*'h80, claim/complete @ 24'h20_0004+CTX*'h1000
//  TIMEOUT      255   max cycles waiting for bus ready before abort (8-bit counter)
//  ENABLE_INIT  32'h0 enable mask written once after reset (bit 0 always forced 0)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   synchronous, active-low reset
//  plic_valid     out  1   bus request, registered
//  plic_addr      out  24  bus address
//  plic_wmask     out  4   4'hF write, 4'h0 read
//  plic_wdata     out  32  write data
//  plic_rdata     in   32  read data, sampled when plic_ready=1
//  plic_ready     in   1   one-cycle acknowledge pulse
//  plic_irq       in   1   context interrupt line from PLIC
//  enable_mask    in   32  new enable value
//  enable_update  in   1   pulse: rewrite enable register with enable_mask
//  id_valid       out  1   claimed ID available
//  id             out  5   claimed source ID (1..31)
//  id_ready       in   1   consumer accepts ID
//  id_done        in   1   pulse: consumer finished servicing id
//  busy           out  1   FSM not in IDLE
//  bus_error      out  1   sticky: a bus transfer timed out; cleared only by reset
//  spurious_cnt   out  8   claims returning 0, saturating
// BEHAVIOUR
//  Reset: all outputs 0; state INIT_EN; enable_pending=0.
//  Bus rule: plic_valid, plic_addr, plic_wmask and plic_wdata are held stable until plic_ready.
//   plic_valid clears on the same edge that samples plic_ready=1, so each request gets exactly one
//   ack. The PLIC acks one cycle after valid, so a transfer takes 2 cycles.
//   While waiting, the wait counter increments. At TIMEOUT: drop plic_valid, set bus_error, go to IDLE.
//  FSM:
//   INIT_EN: write ENABLE_INIT&~1 to the enable address -> IDLE on ack.
//   IDLE: if enable_pending or enable_update -> EN_WR.
//    else if plic_irq -> CLAIM. Enable update wins over a simultaneous IRQ.
//   EN_WR: write enable_mask&~1 (captured on entry) -> IDLE on ack; clear enable_pending.
//   CLAIM: read claim address. On ack: rdata[4:0]==0 -> spurious_cnt+1 (saturate at 255), IDLE.
//    Otherwise latch id=rdata[4:0] -> DELIVER.
//   DELIVER: id_valid=1; id_valid&&id_ready -> SERVICE, id_valid drops next cycle.
//   SERVICE: wait id_done -> COMPLETE. An id_done outside SERVICE is ignored.
//   COMPLETE: write wdata={27'b0,id} to claim address -> IDLE on ack.
//  enable_update outside IDLE sets enable_pending. It is serviced at the next IDLE, before any claim.
//  One interrupt is in flight at a time. A level source still high re-pends and is claimed again.
//  id_done arriving in the same cycle as the handshake is ignored; the consumer must re-pulse.
//  Reset mid-transfer aborts it: plic_valid=0 on the next edge and no complete is issued.
//   The PLIC shares resetn.
// STRUCTURE
//  Shared package: state encoding, PLIC offsets (ENABLE_BASE 'h2000, ENABLE_STRIDE 'h80,
//   CLAIM_BASE 'h20_0004, CLAIM_STRIDE 'h1000), and wmask constants.
//  Sub-module plic_bus_xfer: single-transfer initiator holding request regs and the timeout counter.
//   Interface: start/addr/wdata/we -> done/rdata/timeout.
// TESTING (bench includes PLIC model with 1-cycle ready)
//  Reset, ENABLE_INIT=32'h0000_0006 -> one write addr 24'h00_2000 wdata 32'h6; busy=0 after 2 cycles.
//  Source 2 high -> read 24'h20_0004 returns 2; id_valid,id=2; id_ready then id_done -> write wdata 2.
//  Claim returns 0 -> no id_valid, no write, spurious_cnt=1; 256 spurious claims -> stays 255.
//  enable_update=1 (mask 32'hFFFF_FFFF) during SERVICE -> after complete, enable write of 32'hFFFF_FFFE
//   precedes the next claim.
//  Ready held 0, TIMEOUT=4 -> plic_valid drops after 4 wait cycles; bus_error=1, state IDLE.
//  CTX=1 -> addresses 24'h00_2080 and 24'h20_1004; resetn low during CLAIM -> plic_valid=0 next edge.

Source files
------------

// File: rtl/plic_claim_agent_pkg.sv
// Shared definitions for the PLIC claim agent: FSM encoding, PLIC register map, write masks.
package plic_claim_agent_pkg;

  typedef enum logic [2:0] {
    S_INIT_EN  = 3'd0,
    S_IDLE     = 3'd1,
    S_EN_WR    = 3'd2,
    S_CLAIM    = 3'd3,
    S_DELIVER  = 3'd4,
    S_SERVICE  = 3'd5,
    S_COMPLETE = 3'd6
  } state_t;

  localparam logic [23:0] ENABLE_BASE   = 24'h00_2000;
  localparam logic [23:0] ENABLE_STRIDE = 24'h00_0080;
  localparam logic [23:0] CLAIM_BASE    = 24'h20_0004;
  localparam logic [23:0] CLAIM_STRIDE  = 24'h00_1000;

  localparam logic [3:0] WMASK_WRITE = 4'hF;
  localparam logic [3:0] WMASK_READ  = 4'h0;

  function automatic logic [23:0] enable_addr(input int unsigned ctx);
    return ENABLE_BASE + 24'(ctx) * ENABLE_STRIDE;
  endfunction

  function automatic logic [23:0] claim_addr(input int unsigned ctx);
    return CLAIM_BASE + 24'(ctx) * CLAIM_STRIDE;
  endfunction

endpackage

// File: rtl/plic_claim_agent_bus_xfer.sv
// Single-transfer PLIC bus initiator: holds the request registers stable until ack or timeout.
module plic_bus_xfer
  import plic_claim_agent_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        done,
  output logic [31:0] rdata,
  output logic        timeout,
  output logic        plic_valid,
  output logic [23:0] plic_addr,
  output logic [3:0]  plic_wmask,
  output logic [31:0] plic_wdata,
  input  logic [31:0] plic_rdata,
  input  logic        plic_ready
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;

  // Valid/ready: a request is presented with plic_valid=1 and its addr/wmask/wdata are frozen
  // until the edge that samples plic_ready=1 (valid clears on that edge) or the wait limit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plic_valid <= 1'b0;
      plic_addr  <= '0;
      plic_wmask <= '0;
      plic_wdata <= '0;
      wait_cnt   <= '0;
    end else if (!plic_valid) begin
      if (start) begin
        plic_valid <= 1'b1;
        plic_addr  <= addr;
        plic_wmask <= we ? WMASK_WRITE : WMASK_READ;
        plic_wdata <= wdata;
        wait_cnt   <= '0;
      end
    end else if (plic_ready) begin
      plic_valid <= 1'b0;
    end else if (wait_cnt == WAIT_LAST) begin
      plic_valid <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign done    = plic_valid && plic_ready;
  assign timeout = plic_valid && !plic_ready && (wait_cnt == WAIT_LAST);
  assign rdata   = plic_rdata;

endmodule

// File: rtl/plic_claim_agent.sv
// PLIC context claim agent: programs the enable register, claims pending IDs, hands them to a
// local consumer and writes the completion once the consumer reports done.
module plic_claim_agent
  import plic_claim_agent_pkg::*;
#(
  parameter int unsigned CTX         = 0,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ENABLE_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        plic_valid,
  output logic [23:0] plic_addr,
  output logic [3:0]  plic_wmask,
  output logic [31:0] plic_wdata,
  input  logic [31:0] plic_rdata,
  input  logic        plic_ready,
  input  logic        plic_irq,
  input  logic [31:0] enable_mask,
  input  logic        enable_update,
  output logic        id_valid,
  output logic [4:0]  id,
  input  logic        id_ready,
  input  logic        id_done,
  output logic        busy,
  output logic        bus_error,
  output logic [7:0]  spurious_cnt,
  output state_t      dbg_state
);

  localparam logic [23:0] EN_ADDR    = enable_addr(CTX);
  localparam logic [23:0] CLAIM_ADDR = claim_addr(CTX);

  state_t      state, state_next;
  logic        issued;
  logic        enable_pending;
  logic [31:0] en_data;
  logic        start, x_we, x_done, x_timeout;
  logic [23:0] x_addr;
  logic [31:0] x_wdata, x_rdata;

  plic_bus_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .addr       (x_addr),
    .wdata      (x_wdata),
    .we         (x_we),
    .done       (x_done),
    .rdata      (x_rdata),
    .timeout    (x_timeout),
    .plic_valid (plic_valid),
    .plic_addr  (plic_addr),
    .plic_wmask (plic_wmask),
    .plic_wdata (plic_wdata),
    .plic_rdata (plic_rdata),
    .plic_ready (plic_ready)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= S_INIT_EN;
      issued         <= 1'b0;
      enable_pending <= 1'b0;
      en_data        <= '0;
      id             <= '0;
      spurious_cnt   <= '0;
      bus_error      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      if (x_done || x_timeout) issued <= 1'b0;
      else if (start)          issued <= 1'b1;
      if (x_timeout) bus_error <= 1'b1;
      // The mask is captured on entry, so an update arriving mid-write re-pends a fresh rewrite.
      if (state == S_IDLE && state_next == S_EN_WR) begin
        en_data        <= enable_mask & ~32'h1;
        enable_pending <= 1'b0;
      end else if (enable_update && state != S_IDLE) begin
        enable_pending <= 1'b1;
      end
      if (state == S_CLAIM && x_done) begin
        if (x_rdata[4:0] == 5'd0) begin
          if (spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 8'd1;
        end else begin
          id <= x_rdata[4:0];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    x_addr     = CLAIM_ADDR;
    x_wdata    = '0;
    x_we       = 1'b0;
    case (state)
      S_INIT_EN: begin
        x_addr  = EN_ADDR;
        x_wdata = ENABLE_INIT & ~32'h1;
        x_we    = 1'b1;
        start   = !issued;
        if (x_done || x_timeout) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (enable_pending || enable_update) state_next = S_EN_WR;
        else if (plic_irq)                   state_next = S_CLAIM;
      end
      S_EN_WR: begin
        x_addr  = EN_ADDR;
        x_wdata = en_data;
        x_we    = 1'b1;
        start   = !issued;
        if (x_done || x_timeout) state_next = S_IDLE;
      end
      S_CLAIM: begin
        start = !issued;
        if (x_timeout) state_next = S_IDLE;
        else if (x_done) state_next = (x_rdata[4:0] == 5'd0) ? S_IDLE : S_DELIVER;
      end
      S_DELIVER: begin
        if (id_ready) state_next = S_SERVICE;
      end
      S_SERVICE: begin
        if (id_done) state_next = S_COMPLETE;
      end
      S_COMPLETE: begin
        x_wdata = {27'b0, id};
        x_we    = 1'b1;
        start   = !issued;
        if (x_done || x_timeout) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign id_valid  = (state == S_DELIVER);
  assign dbg_state = state;

endmodule

// File: tb/tb_plic_claim_agent.sv
// Bench for plic_claim_agent: PLIC model with scoreboarded bus transfers, claim vector table,
// and hand-written enable-update, saturation, timeout, CTX=1 and mid-claim reset sequences.
module tb_plic_claim_agent;
  import plic_claim_agent_pkg::*;

  localparam int W = 57;
  localparam logic [23:0] EN0    = 24'h00_2000;
  localparam logic [23:0] CLAIM0 = 24'h20_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, plic_valid, plic_ready, plic_irq, enable_update;
  logic [23:0] plic_addr;
  logic [3:0]  plic_wmask;
  logic [31:0] plic_wdata, plic_rdata, enable_mask;
  logic        id_valid, id_ready, id_done, busy, bus_error;
  logic [4:0]  id;
  logic [7:0]  spurious_cnt;
  state_t      dbg_state;

  logic        resetn_1, plic_valid_1, plic_ready_1, plic_irq_1;
  logic [23:0] plic_addr_1;
  logic [3:0]  plic_wmask_1;
  logic [31:0] plic_wdata_1, plic_rdata_1;
  logic        id_valid_1, busy_1, bus_error_1;
  logic [4:0]  id_1;
  logic [7:0]  spurious_cnt_1;
  state_t      dbg_state_1;

  plic_claim_agent #(.CTX(0), .TIMEOUT(4), .ENABLE_INIT(32'h0000_0006)) u_dut0 (
    .clk(clk), .resetn(resetn), .plic_valid(plic_valid), .plic_addr(plic_addr),
    .plic_wmask(plic_wmask), .plic_wdata(plic_wdata), .plic_rdata(plic_rdata),
    .plic_ready(plic_ready), .plic_irq(plic_irq), .enable_mask(enable_mask),
    .enable_update(enable_update), .id_valid(id_valid), .id(id), .id_ready(id_ready),
    .id_done(id_done), .busy(busy), .bus_error(bus_error), .spurious_cnt(spurious_cnt),
    .dbg_state(dbg_state)
  );

  plic_claim_agent #(.CTX(1), .TIMEOUT(255), .ENABLE_INIT(32'h0)) u_dut1 (
    .clk(clk), .resetn(resetn_1), .plic_valid(plic_valid_1), .plic_addr(plic_addr_1),
    .plic_wmask(plic_wmask_1), .plic_wdata(plic_wdata_1), .plic_rdata(plic_rdata_1),
    .plic_ready(plic_ready_1), .plic_irq(plic_irq_1), .enable_mask(32'h0),
    .enable_update(1'b0), .id_valid(id_valid_1), .id(id_1), .id_ready(1'b0),
    .id_done(1'b0), .busy(busy_1), .bus_error(bus_error_1), .spurious_cnt(spurious_cnt_1),
    .dbg_state(dbg_state_1)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  claim_ret;
  logic         hold_ready, seen, saw_idv;
  int           exp_spur;

  typedef struct {
    logic [31:0] ret;
    logic        exp_valid;
    logic [4:0]  exp_id;
    logic        done_at_hs;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] wr(input logic [23:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [W-1:0] rd(input logic [23:0] a);
    return {1'b0, a, 32'h0};
  endfunction

  // PLIC model for dut0: ack one cycle after valid is seen; each acked transfer is scored.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!resetn) begin
      plic_ready = 1'b0;
      seen       = 1'b0;
    end else if (plic_valid && !plic_ready && !hold_ready) begin
      if (seen) begin
        plic_ready = 1'b1;
        plic_rdata = claim_ret;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_extra: got addr=%h wmask=%h wdata=%h expected no transfer",
                   plic_addr, plic_wmask, plic_wdata);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", 64'(plic_addr), 64'(e[55:32]));
          check("bus_wmask", 64'(plic_wmask), 64'({4{e[56]}}));
          if (e[56]) check("bus_wdata", 64'(plic_wdata), 64'(e[31:0]));
        end
      end else begin
        seen = 1'b1;
      end
    end else begin
      plic_ready = 1'b0;
      if (!plic_valid) seen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!resetn_1) plic_ready_1 = 1'b0;
    else           plic_ready_1 = plic_valid_1 && !plic_ready_1;
    plic_rdata_1 = 32'h3;
  end

  always @(negedge clk) if (id_valid) saw_idv = 1'b1;

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(dbg_state == S_IDLE && exp_q.size() == 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 100), 64'd1);
    if (n >= 100) exp_q.delete();
  endtask

  task automatic wait_id_valid(input string name);
    int n = 0;
    while (!id_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(id_valid), 64'd1);
  endtask

  task automatic pulse_irq();
    @(negedge clk);
    plic_irq = 1'b1;
    @(negedge clk);
    plic_irq = 1'b0;
  endtask

  task automatic handshake_id();
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0; plic_irq = 1'b0; enable_mask = '0; enable_update = 1'b0;
    id_ready = 1'b0; id_done = 1'b0; claim_ret = '0; hold_ready = 1'b0;
    plic_rdata = '0; plic_ready = 1'b0; seen = 1'b0; saw_idv = 1'b0; exp_spur = 0;
    resetn_1 = 1'b0; plic_irq_1 = 1'b0; plic_rdata_1 = '0; plic_ready_1 = 1'b0;

    vecs[0] = '{32'h0000_0002, 1'b1, 5'd2,  1'b0};
    vecs[1] = '{32'h0000_0000, 1'b0, 5'd0,  1'b0};
    vecs[2] = '{32'h0000_001F, 1'b1, 5'd31, 1'b1};
    vecs[3] = '{32'hFFFF_FFE5, 1'b1, 5'd5,  1'b0};
    vecs[4] = '{32'h0000_0040, 1'b0, 5'd0,  1'b0};

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(plic_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_bus_error", 64'(bus_error), 64'd0);
    check("rst_spurious", 64'(spurious_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_INIT_EN));

    exp_q.push_back(wr(EN0, 32'h6));
    resetn = 1'b1;
    wait_idle("init_idle");
    check("init_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++) begin
      claim_ret = vecs[i].ret;
      saw_idv = 1'b0;
      exp_q.push_back(rd(CLAIM0));
      pulse_irq();
      if (vecs[i].exp_valid) begin
        wait_id_valid("vec_id_valid");
        check("vec_id", 64'(id), 64'(vecs[i].exp_id));
        @(negedge clk);
        check("vec_id_hold", 64'(id_valid), 64'd1);
        id_done = vecs[i].done_at_hs;
        handshake_id();
        id_done = 1'b0;
        check("vec_id_drop", 64'(id_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("vec_service", 64'(dbg_state), 64'(S_SERVICE));
        exp_q.push_back(wr(CLAIM0, {27'b0, vecs[i].exp_id}));
        id_done = 1'b1;
        @(negedge clk);
        id_done = 1'b0;
      end else begin
        exp_spur = (exp_spur < 255) ? exp_spur + 1 : 255;
      end
      wait_idle("vec_idle");
      check("vec_spurious", 64'(spurious_cnt), 64'(exp_spur));
      if (!vecs[i].exp_valid) check("vec_no_id_valid", 64'(saw_idv), 64'd0);
    end

    // Enable update during SERVICE must be written after the complete and before the next claim.
    claim_ret = 32'h9;
    exp_q.push_back(rd(CLAIM0));
    pulse_irq();
    wait_id_valid("upd_id_valid");
    handshake_id();
    check("upd_service", 64'(dbg_state), 64'(S_SERVICE));
    enable_mask = 32'hFFFF_FFFF;
    enable_update = 1'b1;
    @(negedge clk);
    enable_update = 1'b0;
    exp_q.push_back(wr(CLAIM0, 32'h9));
    exp_q.push_back(wr(EN0, 32'hFFFF_FFFE));
    exp_q.push_back(rd(CLAIM0));
    claim_ret = 32'h0;
    plic_irq = 1'b1;
    id_done = 1'b1;
    @(negedge clk);
    id_done = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    plic_irq = 1'b0;
    check("upd_order_done", 64'(n < 60), 64'd1);
    exp_spur = (exp_spur < 255) ? exp_spur + 1 : 255;
    wait_idle("upd_idle");
    check("upd_spurious", 64'(spurious_cnt), 64'(exp_spur));

    repeat (256) begin
      claim_ret = 32'h0;
      exp_q.push_back(rd(CLAIM0));
      pulse_irq();
      wait_idle("sat_idle");
      exp_spur = (exp_spur < 255) ? exp_spur + 1 : 255;
    end
    check("sat_spurious", 64'(spurious_cnt), 64'(exp_spur));
    check("sat_value", 64'(spurious_cnt), 64'd255);

    // Ready withheld: the claim read must abort after TIMEOUT=4 wait cycles.
    hold_ready = 1'b1;
    pulse_irq();
    n = 0;
    while (!plic_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("to_valid_rise", 64'(plic_valid), 64'd1);
    n = 0;
    while (plic_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 64'(n), 64'd4);
    check("to_bus_error", 64'(bus_error), 64'd1);
    check("to_state", 64'(dbg_state), 64'(S_IDLE));
    check("to_busy", 64'(busy), 64'd0);
    hold_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("to_sticky", 64'(bus_error), 64'd1);

    // CTX=1 addressing and reset in the middle of a claim.
    resetn_1 = 1'b1;
    n = 0;
    while (!plic_valid_1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ctx1_en_addr", 64'(plic_addr_1), 64'h00_2080);
    check("ctx1_en_wmask", 64'(plic_wmask_1), 64'hF);
    check("ctx1_en_wdata", 64'(plic_wdata_1), 64'h0);
    n = 0;
    while (dbg_state_1 != S_IDLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ctx1_idle", 64'(dbg_state_1), 64'(S_IDLE));
    @(negedge clk);
    plic_irq_1 = 1'b1;
    @(negedge clk);
    plic_irq_1 = 1'b0;
    n = 0;
    while (!plic_valid_1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ctx1_claim_addr", 64'(plic_addr_1), 64'h20_1004);
    check("ctx1_claim_wmask", 64'(plic_wmask_1), 64'h0);
    check("ctx1_claim_state", 64'(dbg_state_1), 64'(S_CLAIM));
    resetn_1 = 1'b0;
    @(negedge clk);
    check("ctx1_rst_valid", 64'(plic_valid_1), 64'd0);
    check("ctx1_rst_state", 64'(dbg_state_1), 64'(S_INIT_EN));
    check("ctx1_rst_busy", 64'(busy_1), 64'd0);
    repeat (2) @(negedge clk);
    check("ctx1_rst_hold", 64'(plic_valid_1), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
